timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped down-counting timer that acts as the responder on the CPU-to-timer bus. The bus bridge decodes a 16-byte window per timer, forwards word address bits [3:2], write enable and write data, and collects this block's interrupt request into the CPU interrupt vector. Two instances sit in the design: timer 0 at 0x00007F00 and timer 1 at 0x00007F10. Each instance holds its own control, preset and count registers and raises an interrupt when its count reaches zero.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  2 (`[3:2]`)  register select.
- `we`  in  1  write strobe; already qualified by the bridge's address decode.
- `din`  in  32  write data from the CPU.
- `dout`  out  32  read data; combinational function of `addr`.
- `intq`  out  1  interrupt request to the bridge.

## Operation
Register map, selected by `addr`:
- 0 = CTRL. Bits [3:0] are writable; bits [31:4] read as 0.
  - [0] En
  - [2:1] Mode: 00 = one-shot, 01 = auto-reload, 1x behaves as 00.
  - [3] IM, the interrupt mask.
- 1 = PRESET. 32-bit read/write.
- 2 = COUNT. Read-only; writes are ignored.
- 3 = reads as 0; writes are ignored.

FSM states are IDLE, LOAD, CNT and INT:
- IDLE: if En = 1, go to LOAD.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - If En = 0, go to IDLE with COUNT frozen.
  - Else if COUNT = 0, go to INT.
  - Else COUNT <= COUNT − 1.
- INT: irq_pending <= 1.
  - Mode 01: go to LOAD.
  - Otherwise: En <= 0 and go to IDLE.

Interrupt output: `intq` = IM & irq_pending.

Clearing irq_pending:
- One-shot mode: cleared by any CPU write to CTRL or PRESET.
- Auto-reload mode: cleared on the edge after it was set, giving a one-cycle pulse.

Write and boundary rules:
- A PRESET write does not affect COUNT until the next LOAD.
- A CTRL write in the same cycle as INT's En clear: the CPU write wins.
- A CTRL write that sets IM while irq_pending = 1 asserts `intq` immediately after that edge.
- A PRESET of 0 is legal: the timer reaches INT one edge after LOAD.
- Re-enabling from IDLE always reloads from PRESET. COUNT does not resume.
- COUNT never wraps below 0.

## Timing
Reset values (asynchronous, effective while `reset` = 1):
- CTRL = 0, PRESET = 0, COUNT = 0.
- State = IDLE.
- irq_pending = 0, so `intq` = 0.
- `dout` = 0 for every `addr`.

Reads and writes:
- Reads have zero latency: `dout` reflects the register state of the current cycle.
- Writes take effect at the edge where `we` = 1.

Latency, with PRESET = N and En written at edge E0:
- E1: state = LOAD.
- E2: COUNT = N, state = CNT.
- E2+k: COUNT = N−k.
- E3+N: state = INT.
- E4+N: irq_pending = 1, so `intq` = 1 if IM = 1.

Auto-reload period is N+3 cycles between `intq` pulses.

Clearing En mid-count: the En = 0 write at edge Ew stops decrementing from edge Ew+1, and COUNT holds its value.

Reset asserted mid-count: immediate return to the reset values, with no interrupt generated.

## Configuration
- `TIMER_AUTORELOAD_EN` defined: Mode 01 auto-reloads exactly as described above.
- Not defined:
  - The LOAD-from-INT path is omitted.
  - Mode 01 behaves identically to one-shot: En is cleared and `intq` is level-held until a CTRL or PRESET write.
  - CTRL[2:1] remain writable and readable.

## Test plan
- Reset, then read addr 0, 1, 2 and 3 -> all read 0 and `intq` = 0.
- Write PRESET = 5, then CTRL = 0x9 (En, IM, one-shot) -> COUNT reads 5, 4, … 0, and `intq` rises 9 edges after the CTRL write. CTRL then reads 0x8, and `intq` stays high until a write of PRESET = 5 clears it.
- With `TIMER_AUTORELOAD_EN` defined: PRESET = 2, CTRL = 0xB -> one-cycle `intq` pulses every 5 cycles; CTRL stays 0xB.
- PRESET = 10, CTRL = 0x1; at COUNT = 6 write CTRL = 0 -> COUNT holds 6 and `intq` never asserts. A later CTRL = 0x9 reloads 10.
- PRESET = 0, CTRL = 0x1 (IM = 0) -> irq_pending is set with `intq` low. A subsequent CTRL = 0x8 raises `intq` the following cycle.
- Attempt to write 0x1234 to COUNT while idle -> COUNT still reads 0. Assert `reset` mid-count -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with one-shot/auto-reload modes and masked interrupt.
// Auto-reload of mode 01 is built only when TIMER_AUTORELOAD_EN is defined.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        intq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;
  logic        reload;
  logic        wr_ctrl;
  logic        wr_pre;
  logic        keep_irq;
`ifdef TIMER_AUTORELOAD_EN
  assign reload = ctrl[2:1] == 2'b01;
`else
  assign reload = 1'b0;
`endif
  assign wr_ctrl = we && addr == 2'd0;
  assign wr_pre  = we && addr == 2'd1;
  // a CTRL write that unmasks a pending interrupt must expose it, not clear it
  assign keep_irq = wr_ctrl && din[3] && !ctrl[3];
  assign intq = ctrl[3] & irq_pending;
  always_comb
    dout = addr == 2'd0 ? {28'd0, ctrl} :
           addr == 2'd1 ? preset :
           addr == 2'd2 ? count : 32'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ctrl        <= 4'd0;
      preset      <= 32'd0;
      count       <= 32'd0;
      irq_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctrl[0]) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT:
          if (!ctrl[0]) state <= IDLE;
          else if (count == 32'd0) state <= INT;
          else count <= count - 32'd1;
        INT: begin
          state <= reload ? LOAD : IDLE;
          if (!reload) ctrl[0] <= 1'b0;
        end
      endcase
      if (wr_ctrl) ctrl <= din[3:0];
      if (wr_pre) preset <= din;
      if (state == INT) irq_pending <= 1'b1;
      else if (reload ? irq_pending : (wr_ctrl && !keep_irq) || wr_pre) irq_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: scoreboard bench for timer_counter; define TIMER_AUTORELOAD_EN to cover auto-reload.
module tb_timer_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        intq;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       nm;
    logic [31:0] d;
    logic        i;
  } exp_t;
  exp_t sb[$];

  timer_counter dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout), .intq(intq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (dout !== e.d || intq !== e.i) begin
        errors++;
        $display("FAIL %s: got dout=%h intq=%b, expected dout=%h intq=%b", e.nm, dout, intq, e.d, e.i);
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic c, input logic [31:0] ed, input logic ei, input string nm);
    @(posedge clk);
    #1;
    reset = r;
    we = w;
    addr = a;
    din = d;
    if (c) sb.push_back('{nm, ed, ei});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ed, input logic ei, input string nm);
    step(1'b0, 1'b0, a, 32'd0, 1'b1, ed, ei, nm);
  endtask

  initial begin
    for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 2'(a), 32'd0, 1'b1, 32'd0, 1'b0, "reset_hold");
    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, 1'b0, "reset_read");
    // one-shot, N=5: intq rises at E9
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int e = 0; e <= 12; e++)
      rd(2'd2, e < 2 ? 32'd0 : (e - 2 > 5 ? 32'd0 : 32'(5 - (e - 2))), e >= 9, "oneshot_count");
    rd(2'd0, 32'h8, 1'b1, "oneshot_ctrl");
    wr(2'd1, 32'd5);
    rd(2'd1, 32'd5, 1'b0, "oneshot_clear");
    rd(2'd2, 32'd0, 1'b0, "oneshot_no_reload");
    // mode 01, N=2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
`ifdef TIMER_AUTORELOAD_EN
    for (int e = 0; e <= 17; e++) rd(2'd0, 32'hB, e == 6 || e == 11 || e == 16, "autoreload_pulse");
    wr(2'd0, 32'd0);
`else
    for (int e = 0; e <= 9; e++) rd(2'd0, e < 6 ? 32'hB : 32'hA, e >= 6, "mode01_oneshot");
    wr(2'd1, 32'd2);
    rd(2'd0, 32'hA, 1'b0, "mode01_clear");
    wr(2'd0, 32'd0);
`endif
    // disable mid-count: COUNT freezes at 6
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int e = 0; e <= 4; e++) rd(2'd2, e < 2 ? 32'd0 : 32'(10 - (e - 2)), 1'b0, "en_count");
    wr(2'd0, 32'd0);
    for (int e = 6; e <= 11; e++) rd(2'd2, 32'd6, 1'b0, "en_hold");
    wr(2'd0, 32'h9);
    rd(2'd2, 32'd6, 1'b0, "reenable_f0");
    rd(2'd2, 32'd6, 1'b0, "reenable_f1");
    rd(2'd2, 32'd10, 1'b0, "reenable_reload");
    rd(2'd2, 32'd9, 1'b0, "reenable_dec");
    wr(2'd0, 32'd0);
    // PRESET 0 with IM=0, then unmask
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    for (int e = 0; e <= 6; e++) rd(2'd0, e < 4 ? 32'h1 : 32'h0, 1'b0, "preset0_masked");
    wr(2'd0, 32'h8);
    rd(2'd0, 32'h8, 1'b1, "unmask_intq");
    rd(2'd0, 32'h8, 1'b1, "unmask_hold");
    wr(2'd1, 32'd0);
    rd(2'd0, 32'h8, 1'b0, "unmask_clear");
    wr(2'd0, 32'd0);
    // read-only COUNT and unused slot
    wr(2'd2, 32'h1234);
    rd(2'd2, 32'd0, 1'b0, "count_ro");
    wr(2'd3, 32'hFFFF);
    rd(2'd3, 32'd0, 1'b0, "slot3_zero");
    // asynchronous reset mid-count
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int e = 0; e <= 4; e++) rd(2'd2, e < 2 ? 32'd0 : 32'(10 - (e - 2)), 1'b0, "pre_reset_count");
    for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 2'((a + 2) % 4), 32'd0, 1'b1, 32'd0, 1'b0, "async_reset");
    for (int e = 0; e < 6; e++) rd(2'd2, 32'd0, 1'b0, "post_reset_idle");
    rd(2'd0, 32'd0, 1'b0, "post_reset_ctrl");
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d checks left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
